gpio_apb_ctrl: RTL and testbench

//  Parametrised APB3 GPIO controller; successor to the fixed 16-bit GPIO/7-seg peripheral.

---
 rtl/gpio_apb_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_gpio_apb_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_apb_ctrl.sv
// rtl/gpio_apb_ctrl.sv - APB3 GPIO controller: byte-strobed OUT, debounced IN, rising-edge IRQ, hex 7-seg driver
// Optional build macro: GPIO_SEG_SCAN_EN selects multiplexed (scanned) 7-seg drive; static drive otherwise.
module gpio_apb_ctrl #(
  parameter int NGPIO    = 16,
  parameter int NDIGIT   = 8,
  parameter int DB_DIV   = 1000,
  parameter int SCAN_DIV = 5000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           in_paddr,
  input  logic                  in_psel,
  input  logic                  in_penable,
  input  logic [2:0]            in_pprot,
  input  logic                  in_pwrite,
  input  logic [31:0]           in_pwdata,
  input  logic [3:0]            in_pstrb,
  output logic                  in_pready,
  output logic [31:0]           in_prdata,
  output logic                  in_pslverr,
  output logic [NGPIO-1:0]      gpio_out,
  input  logic [NGPIO-1:0]      gpio_in,
  output logic [NDIGIT*8-1:0]   gpio_seg,
  output logic [NDIGIT-1:0]     gpio_seg_an,
  output logic                  gpio_irq
);

  localparam int DBW = (DB_DIV > 2) ? $clog2(DB_DIV) : 1;

  logic [2:0]           addr;
  logic                 access;
  logic                 wr_en;
  logic [31:0]          wmask;
  logic                 unused_bits;

  logic [NGPIO-1:0]     out_q, out_d;
  logic [NDIGIT*4-1:0]  seg_q, seg_d;
  logic [NGPIO-1:0]     en_q, en_d;
  logic [NGPIO-1:0]     stat_q, stat_d;
  logic [NDIGIT-1:0]    blank_q, blank_d;
  logic [NGPIO-1:0]     clr;

  logic [NGPIO-1:0]     sync1_q, sync2_q;
  logic [NGPIO-1:0]     samp_q, samp_d;
  logic [NGPIO-1:0]     in_q, in_d, in_prev_q;
  logic [NGPIO-1:0]     agree;
  logic [DBW-1:0]       db_cnt_q;
  logic                 tick;
  logic                 irq_q;

  logic [NDIGIT*8-1:0]  pat;

  // Upper address bits and protection attributes carry no meaning here.
  assign unused_bits = ^{in_pprot, in_paddr[31:5], in_paddr[1:0]};

  assign addr       = in_paddr[4:2];
  assign access     = in_psel & in_penable;
  assign in_pready  = 1'b1;
  assign in_pslverr = access & ((addr > 3'd5) | (in_pwrite & (addr == 3'd1)));
  assign wr_en      = access & in_pwrite & ~in_pslverr;
  assign wmask      = {{8{in_pstrb[3]}}, {8{in_pstrb[2]}}, {8{in_pstrb[1]}}, {8{in_pstrb[0]}}};

  // Register file next-state: byte-merged writes, W1C with set taking priority.
  always_comb begin
    out_d   = out_q;
    seg_d   = seg_q;
    en_d    = en_q;
    blank_d = blank_q;
    clr     = '0;
    if (wr_en) begin
      case (addr)
        3'd0: out_d   = (out_q & ~wmask[NGPIO-1:0]) | (in_pwdata[NGPIO-1:0] & wmask[NGPIO-1:0]);
        3'd2: seg_d   = (seg_q & ~wmask[NDIGIT*4-1:0]) | (in_pwdata[NDIGIT*4-1:0] & wmask[NDIGIT*4-1:0]);
        3'd3: en_d    = (en_q & ~wmask[NGPIO-1:0]) | (in_pwdata[NGPIO-1:0] & wmask[NGPIO-1:0]);
        3'd4: clr     = in_pwdata[NGPIO-1:0] & wmask[NGPIO-1:0];
        3'd5: blank_d = (blank_q & ~wmask[NDIGIT-1:0]) | (in_pwdata[NDIGIT-1:0] & wmask[NDIGIT-1:0]);
        default: ;
      endcase
    end
    stat_d = (stat_q & ~clr) | (in_q & ~in_prev_q);
  end

  // Debounce: IN only follows the synced input once two consecutive tick samples agree.
  always_comb begin
    tick   = (db_cnt_q == DBW'(DB_DIV - 1));
    agree  = ~(sync2_q ^ samp_q);
    samp_d = tick ? sync2_q : samp_q;
    in_d   = tick ? ((in_q & ~agree) | (sync2_q & agree)) : in_q;
  end

  // All state: registers, synchroniser, debounce counter and registered interrupt.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_q     <= '0;
      seg_q     <= '0;
      en_q      <= '0;
      stat_q    <= '0;
      blank_q   <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      samp_q    <= '0;
      in_q      <= '0;
      in_prev_q <= '0;
      db_cnt_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      seg_q     <= seg_d;
      en_q      <= en_d;
      stat_q    <= stat_d;
      blank_q   <= blank_d;
      sync1_q   <= gpio_in;
      sync2_q   <= sync1_q;
      samp_q    <= samp_d;
      in_q      <= in_d;
      in_prev_q <= in_q;
      db_cnt_q  <= tick ? '0 : db_cnt_q + 1'b1;
      irq_q     <= |(stat_q & en_q);
    end
  end

  assign gpio_out = out_q;
  assign gpio_irq = irq_q;

  // Read mux is purely address-decoded; unused bits and holes read zero.
  always_comb begin
    case (addr)
      3'd0:    in_prdata = 32'(out_q);
      3'd1:    in_prdata = 32'(in_q);
      3'd2:    in_prdata = 32'(seg_q);
      3'd3:    in_prdata = 32'(en_q);
      3'd4:    in_prdata = 32'(stat_q);
      3'd5:    in_prdata = 32'(blank_q);
      default: in_prdata = 32'h0;
    endcase
  end

  function automatic logic [7:0] seg_decode(input logic [3:0] n);
    logic [7:0] on;
    case (n)
      4'h0: on = 8'hFC;  4'h1: on = 8'h60;  4'h2: on = 8'hDA;  4'h3: on = 8'hF2;
      4'h4: on = 8'h66;  4'h5: on = 8'hB6;  4'h6: on = 8'hBE;  4'h7: on = 8'hE0;
      4'h8: on = 8'hFE;  4'h9: on = 8'hF6;  4'hA: on = 8'hEE;  4'hB: on = 8'h3E;
      4'hC: on = 8'h9C;  4'hD: on = 8'h7A;  4'hE: on = 8'h9E;  default: on = 8'h8E;
    endcase
    return ~on;
  endfunction

  // Per-digit active-low segment pattern, blanking forces all segments off.
  always_comb begin
    for (int i = 0; i < NDIGIT; i++) begin
      pat[i*8 +: 8] = blank_q[i] ? 8'hFF : seg_decode(seg_q[i*4 +: 4]);
    end
  end

`ifdef GPIO_SEG_SCAN_EN
  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (NDIGIT > 1) ? $clog2(NDIGIT) : 1;

  logic [SW-1:0] scan_cnt_q;
  logic [DW-1:0] dig_q;

  // Scan position advances every SCAN_DIV cycles and wraps after the last digit.
  always_ff @(posedge clock) begin
    if (reset) begin
      scan_cnt_q <= '0;
      dig_q      <= '0;
    end else if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
      scan_cnt_q <= '0;
      dig_q      <= (dig_q == DW'(NDIGIT - 1)) ? '0 : dig_q + 1'b1;
    end else begin
      scan_cnt_q <= scan_cnt_q + 1'b1;
    end
  end

  // Only the selected digit is lit; a blanked digit still owns its slot.
  always_comb begin
    gpio_seg    = '1;
    gpio_seg_an = '1;
    for (int i = 0; i < NDIGIT; i++) begin
      if (DW'(i) == dig_q) begin
        gpio_seg[i*8 +: 8] = pat[i*8 +: 8];
        gpio_seg_an[i]     = 1'b0;
      end
    end
  end
`else
  assign gpio_seg    = pat;
  assign gpio_seg_an = '0;
`endif

endmodule

// File: tb/tb_gpio_apb_ctrl.sv
// tb/tb_gpio_apb_ctrl.sv - directed table-driven bench for gpio_apb_ctrl
module tb_gpio_apb_ctrl;

  localparam int NGPIO  = 16;
  localparam int NDIGIT = 8;

  logic                clock = 1'b0;
  logic                reset;
  logic [31:0]         paddr;
  logic                psel, penable, pwrite;
  logic [2:0]          pprot;
  logic [31:0]         pwdata;
  logic [3:0]          pstrb;
  logic                pready;
  logic [31:0]         prdata;
  logic                pslverr;
  logic [NGPIO-1:0]    gpio_out;
  logic [NGPIO-1:0]    gpio_in;
  logic [NDIGIT*8-1:0] gpio_seg;
  logic [NDIGIT-1:0]   gpio_seg_an;
  logic                gpio_irq;

  int checks = 0;
  int errors = 0;

  gpio_apb_ctrl #(.NGPIO(NGPIO), .NDIGIT(NDIGIT), .DB_DIV(4), .SCAN_DIV(4)) dut (
    .clock(clock), .reset(reset),
    .in_paddr(paddr), .in_psel(psel), .in_penable(penable), .in_pprot(pprot),
    .in_pwrite(pwrite), .in_pwdata(pwdata), .in_pstrb(pstrb),
    .in_pready(pready), .in_prdata(prdata), .in_pslverr(pslverr),
    .gpio_out(gpio_out), .gpio_in(gpio_in), .gpio_seg(gpio_seg),
    .gpio_seg_an(gpio_seg_an), .gpio_irq(gpio_irq)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        wr;
    logic [31:0] pa;
    logic [31:0] wd;
    logic [3:0]  st;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[26];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic [31:0] pa, input logic [31:0] wd,
                     input logic [3:0] st, output logic [31:0] rd, output logic err);
    @(negedge clock);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = pa; pwdata = wd; pstrb = st;
    @(negedge clock);
    penable = 1'b1;
    #1;
    rd  = prdata;
    err = pslverr;
    @(posedge clock);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  logic [31:0] rd;
  logic        err;
  int          irq_hi;
  int          k;

  initial begin
    reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = '0; gpio_in = '0;

    vecs[0]  = '{1'b0, 32'h00, 32'h0,         4'h0, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 32'h04, 32'h0,         4'h0, 32'h0,         1'b0};
    vecs[2]  = '{1'b0, 32'h08, 32'h0,         4'h0, 32'h0,         1'b0};
    vecs[3]  = '{1'b0, 32'h0C, 32'h0,         4'h0, 32'h0,         1'b0};
    vecs[4]  = '{1'b0, 32'h10, 32'h0,         4'h0, 32'h0,         1'b0};
    vecs[5]  = '{1'b0, 32'h14, 32'h0,         4'h0, 32'h0,         1'b0};
    vecs[6]  = '{1'b1, 32'h00, 32'hA5A5_1234, 4'h1, 32'h0,         1'b0};
    vecs[7]  = '{1'b0, 32'h00, 32'h0,         4'h0, 32'h0000_0034, 1'b0};
    vecs[8]  = '{1'b1, 32'h00, 32'hA5A5_1234, 4'h2, 32'h0,         1'b0};
    vecs[9]  = '{1'b0, 32'h00, 32'h0,         4'h0, 32'h0000_1234, 1'b0};
    vecs[10] = '{1'b1, 32'h00, 32'hFFFF_FFFF, 4'hC, 32'h0,         1'b0};
    vecs[11] = '{1'b0, 32'h00, 32'h0,         4'h0, 32'h0000_1234, 1'b0};
    vecs[12] = '{1'b1, 32'h04, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
    vecs[13] = '{1'b0, 32'h04, 32'h0,         4'h0, 32'h0,         1'b0};
    vecs[14] = '{1'b0, 32'h18, 32'h0,         4'h0, 32'h0,         1'b1};
    vecs[15] = '{1'b0, 32'h1C, 32'h0,         4'h0, 32'h0,         1'b1};
    vecs[16] = '{1'b1, 32'h08, 32'h0123_89AF, 4'hF, 32'h0,         1'b0};
    vecs[17] = '{1'b0, 32'h1000_0008, 32'h0,  4'h0, 32'h0123_89AF, 1'b0};
    vecs[18] = '{1'b1, 32'h14, 32'hFFFF_FF80, 4'h1, 32'h0,         1'b0};
    vecs[19] = '{1'b0, 32'h14, 32'h0,         4'h0, 32'h0000_0080, 1'b0};
    vecs[20] = '{1'b1, 32'h0C, 32'h0000_0008, 4'hF, 32'h0,         1'b0};
    vecs[21] = '{1'b0, 32'h0C, 32'h0,         4'h0, 32'h0000_0008, 1'b0};
    vecs[22] = '{1'b1, 32'h18, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
    vecs[23] = '{1'b0, 32'h00, 32'h0,         4'h0, 32'h0000_1234, 1'b0};
    vecs[24] = '{1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b0};
    vecs[25] = '{1'b0, 32'h10, 32'h0,         4'h0, 32'h0,         1'b0};

    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("reset_gpio_out", 64'(gpio_out), 64'h0);
    chk("reset_irq", 64'(gpio_irq), 64'h0);
    chk("pready", 64'(pready), 64'h1);
`ifndef GPIO_SEG_SCAN_EN
    chk("reset_seg", 64'(gpio_seg), {8{8'h03}});
    chk("reset_seg_an", 64'(gpio_seg_an), 64'h0);
`endif

    for (int i = 0; i < 26; i++) begin
      apb(vecs[i].wr, vecs[i].pa, vecs[i].wd, vecs[i].st, rd, err);
      chk($sformatf("vec%0d_pslverr", i), 64'(err), 64'(vecs[i].exp_err));
      if (!vecs[i].wr) chk($sformatf("vec%0d_prdata", i), 64'(rd), 64'(vecs[i].exp_rd));
      if (i == 7) chk("gpio_out_byte0", 64'(gpio_out), 64'h0034);
    end

    chk("gpio_out_final", 64'(gpio_out), 64'h1234);
`ifndef GPIO_SEG_SCAN_EN
    chk("digit0", 64'(gpio_seg[7:0]), 64'h71);
    chk("digit1", 64'(gpio_seg[15:8]), 64'h11);
    chk("digit2", 64'(gpio_seg[23:16]), 64'h09);
    chk("digit7_blank", 64'(gpio_seg[63:56]), 64'hFF);
`endif

    // Debounced rise on bit 3: not visible immediately, visible within the bound.
    gpio_in[3] = 1'b1;
    apb(1'b0, 32'h04, 32'h0, 4'h0, rd, err);
    chk("in_early", 64'(rd), 64'h0);
    repeat (10) @(posedge clock);
    apb(1'b0, 32'h04, 32'h0, 4'h0, rd, err);
    chk("in_rise3", 64'(rd), 64'h8);

    // One-cycle glitch on bit 5 must not reach IN.
    gpio_in[5] = 1'b1;
    @(posedge clock);
    #1;
    gpio_in[5] = 1'b0;
    repeat (12) @(posedge clock);
    apb(1'b0, 32'h04, 32'h0, 4'h0, rd, err);
    chk("in_glitch5", 64'(rd), 64'h8);

    // Interrupt from bit 3 rise with IRQ_EN bit 3 set.
    #1;
    chk("irq_after_rise", 64'(gpio_irq), 64'h1);
    apb(1'b0, 32'h10, 32'h0, 4'h0, rd, err);
    chk("stat_after_rise", 64'(rd), 64'h8);
    apb(1'b1, 32'h10, 32'h8, 4'hF, rd, err);
    apb(1'b0, 32'h10, 32'h0, 4'h0, rd, err);
    chk("stat_w1c", 64'(rd), 64'h0);
    #1;
    chk("irq_after_w1c", 64'(gpio_irq), 64'h0);

    // Drop bit 3 and let the debouncer settle low.
    gpio_in[3] = 1'b0;
    repeat (14) @(posedge clock);
    apb(1'b0, 32'h04, 32'h0, 4'h0, rd, err);
    chk("in_fall3", 64'(rd), 64'h0);

    // Hold a W1C of bit 3 every cycle across a new rise: the set must win for exactly one cycle.
    @(negedge clock);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h8; pstrb = 4'hF;
    @(negedge clock);
    penable = 1'b1;
    gpio_in[3] = 1'b1;
    irq_hi = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clock);
      #1;
      if (gpio_irq) irq_hi++;
    end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    chk("set_wins_irq_cycles", 64'(irq_hi), 64'd1);
    apb(1'b0, 32'h10, 32'h0, 4'h0, rd, err);
    chk("stat_after_hold", 64'(rd), 64'h0);

`ifdef GPIO_SEG_SCAN_EN
    k = 0;
    while (gpio_seg_an !== 8'hFE && k < 100) begin
      @(posedge clock);
      #1;
      k++;
    end
    chk("scan_find_fe", 64'(gpio_seg_an), 64'hFE);
    for (int s = 1; s <= 8; s++) begin
      repeat (4) @(posedge clock);
      #1;
      chk($sformatf("scan_step%0d", s), 64'(gpio_seg_an), 64'(~(8'h01 << (s % 8))));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
